// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback wins every cycle, LLU
// results wait in a small FIFO and drain into idle write-port cycles.
module rf_write_arbiter #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              wb_valid,
  input  logic [4:0]        wb_wsel,
  input  logic [WORD_W-1:0] wb_wdat,
  input  logic              llu_valid,
  input  logic [4:0]        llu_wsel,
  input  logic [WORD_W-1:0] llu_wdat,
  output logic              llu_ready,
  output logic              rf_wen,
  output logic [4:0]        rf_wsel,
  output logic [WORD_W-1:0] rf_wdat,
  input  logic [4:0]        q_sel,
  output logic              q_busy
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} fifo_state_e;

  fifo_state_e                   state_q, state_d;
  logic [CW-1:0]                 count_q, count_d;
  logic [PW-1:0]                 rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [DEPTH-1:0][4:0]         ent_sel_q, ent_sel_d;
  logic [DEPTH-1:0][WORD_W-1:0]  ent_dat_q, ent_dat_d;
  logic                          rf_wen_q, rf_wen_d;
  logic [4:0]                    rf_wsel_q, rf_wsel_d;
  logic [WORD_W-1:0]             rf_wdat_q, rf_wdat_d;

  logic wb_take, pop, push, fifo_hit;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign llu_ready = (count_q < CW'(DEPTH));
  assign wb_take   = wb_valid && (wb_wsel != 5'd0);
  // A wb write to r0 is dropped, so it leaves the port free for a pop.
  assign pop       = (state_q != EMPTY) && !wb_take;
  assign push      = llu_valid && llu_ready && (llu_wsel != 5'd0);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    ent_sel_d = ent_sel_q;
    ent_dat_d = ent_dat_q;
    rf_wen_d  = 1'b0;
    rf_wsel_d = rf_wsel_q;
    rf_wdat_d = rf_wdat_q;

    if (wb_take) begin
      rf_wen_d  = 1'b1;
      rf_wsel_d = wb_wsel;
      rf_wdat_d = wb_wdat;
    end else if (pop) begin
      rf_wen_d  = 1'b1;
      rf_wsel_d = ent_sel_q[rd_ptr_q];
      rf_wdat_d = ent_dat_q[rd_ptr_q];
    end

    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push) begin
      ent_sel_d[wr_ptr_q] = llu_wsel;
      ent_dat_d[wr_ptr_q] = llu_wdat;
      wr_ptr_d            = ptr_inc(wr_ptr_q);
    end

    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;

    if (count_d == '0)                state_d = EMPTY;
    else if (count_d == CW'(DEPTH))   state_d = FULL;
    else                              state_d = PARTIAL;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= EMPTY;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      ent_sel_q <= '0;
      ent_dat_q <= '0;
      rf_wen_q  <= 1'b0;
      rf_wsel_q <= '0;
      rf_wdat_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      ent_sel_q <= ent_sel_d;
      ent_dat_q <= ent_dat_d;
      rf_wen_q  <= rf_wen_d;
      rf_wsel_q <= rf_wsel_d;
      rf_wdat_q <= rf_wdat_d;
    end
  end

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    fifo_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((((i >= int'(rd_ptr_q)) ? (i - int'(rd_ptr_q)) : (i + DEPTH - int'(rd_ptr_q)))
           < int'(count_q)) && (ent_sel_q[i] == q_sel))
        fifo_hit = 1'b1;
    end
  end

  assign q_busy  = (q_sel != 5'd0) && (fifo_hit || (rf_wen_q && (rf_wsel_q == q_sel)));
  assign rf_wen  = rf_wen_q;
  assign rf_wsel = rf_wsel_q;
  assign rf_wdat = rf_wdat_q;
endmodule
